mc_ctrl_fsm: RTL and testbench

//  Multi-cycle control FSM that drives the ALU control interface (alu_op, ins) and consumes its

---
 rtl/mc_ctrl_fsm_pkg.sv | 65 ++++++
 rtl/mc_ctrl_fsm_alu_dec.sv | 70 +++++++
 rtl/mc_ctrl_fsm.sv | 154 +++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states,
// ALU op / overflow-check codes, and opcode / funct values.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MADDR  = 4'd2,
    S_MRD    = 4'd3,
    S_MWB    = 4'd4,
    S_MWR    = 4'd5,
    S_EXR    = 4'd6,
    S_RWB    = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9,
    S_EXI    = 4'd10,
    S_IWB    = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [3:0] ALU_OP_ZERO = 4'd0;
  localparam logic [3:0] ALU_OP_ADD  = 4'd1;
  localparam logic [3:0] ALU_OP_SUB  = 4'd2;
  localparam logic [3:0] ALU_OP_AND  = 4'd3;
  localparam logic [3:0] ALU_OP_OR   = 4'd4;
  localparam logic [3:0] ALU_OP_XOR  = 4'd5;
  localparam logic [3:0] ALU_OP_NOR  = 4'd6;
  localparam logic [3:0] ALU_OP_SLTU = 4'd7;
  localparam logic [3:0] ALU_OP_SLT  = 4'd8;

  localparam logic [1:0] INS_NONE = 2'b00;
  localparam logic [1:0] INS_ADD  = 2'b01;
  localparam logic [1:0] INS_SUB  = 2'b10;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Immediate-ALU opcodes all share the EXI/IWB path.
  function automatic logic is_imm_op(input logic [5:0] op);
    return (op >= OP_ADDI) && (op <= OP_XORI);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// ALU control decode: maps the current state plus IR fields onto the ALU
// op / overflow-check code, the immediate extension mode and a legality flag.
module mc_alu_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic [1:0] ins_o,
  output logic       ext_zero_o,
  output logic       legal_o
);

  // Legality depends only on the IR so DECODE can divert to TRAP early.
  always_comb begin
    legal_o = 1'b0;
    case (opcode_i)
      OP_R: begin
        case (funct_i)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
          FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: legal_o = 1'b1;
          default:                                legal_o = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal_o = 1'b1;
      default:                            legal_o = is_imm_op(opcode_i);
    endcase
  end

  // Per-state ALU function; states that do not use the ALU request ZERO.
  always_comb begin
    alu_op_o   = ALU_OP_ZERO;
    ins_o      = INS_NONE;
    ext_zero_o = 1'b0;
    case (state_i)
      S_FETCH, S_DECODE, S_MADDR: alu_op_o = ALU_OP_ADD;
      S_BR:                       alu_op_o = ALU_OP_SUB;
      S_EXR: begin
        case (funct_i)
          FN_ADD:  begin alu_op_o = ALU_OP_ADD; ins_o = INS_ADD; end
          FN_ADDU: alu_op_o = ALU_OP_ADD;
          FN_SUB:  begin alu_op_o = ALU_OP_SUB; ins_o = INS_SUB; end
          FN_SUBU: alu_op_o = ALU_OP_SUB;
          FN_AND:  alu_op_o = ALU_OP_AND;
          FN_OR:   alu_op_o = ALU_OP_OR;
          FN_XOR:  alu_op_o = ALU_OP_XOR;
          FN_NOR:  alu_op_o = ALU_OP_NOR;
          FN_SLT:  alu_op_o = ALU_OP_SLT;
          FN_SLTU: alu_op_o = ALU_OP_SLTU;
          default: alu_op_o = ALU_OP_ZERO;
        endcase
      end
      S_EXI: begin
        case (opcode_i)
          OP_ADDI:  begin alu_op_o = ALU_OP_ADD; ins_o = INS_ADD; end
          OP_ADDIU: alu_op_o = ALU_OP_ADD;
          OP_SLTI:  alu_op_o = ALU_OP_SLT;
          OP_SLTIU: alu_op_o = ALU_OP_SLTU;
          OP_ANDI:  begin alu_op_o = ALU_OP_AND; ext_zero_o = 1'b1; end
          OP_ORI:   begin alu_op_o = ALU_OP_OR;  ext_zero_o = 1'b1; end
          OP_XORI:  begin alu_op_o = ALU_OP_XOR; ext_zero_o = 1'b1; end
          default:  alu_op_o = ALU_OP_ZERO;
        endcase
      end
      default: alu_op_o = ALU_OP_ZERO;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences PC / memory / IR / regfile strobes,
// drives ALU control, traps on checked overflow or illegal instructions, and
// counts retired instructions and traps.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             overflow,
  output logic [3:0]       alu_op,
  output logic [1:0]       ins,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] trap_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] trap_cnt_q, trap_cnt_d;

  logic [3:0] dec_alu_op;
  logic [1:0] dec_ins;
  logic       dec_ext_zero;
  logic       dec_legal;
  logic       ovf_trap;
  logic       retire;

  mc_alu_dec u_alu_dec (
    .state_i    (state_q),
    .opcode_i   (opcode),
    .funct_i    (funct),
    .alu_op_o   (dec_alu_op),
    .ins_o      (dec_ins),
    .ext_zero_o (dec_ext_zero),
    .legal_o    (dec_legal)
  );

  // Only the signed (checked) forms may trap; unsigned forms ignore the flag.
  assign ovf_trap = overflow && (dec_ins != INS_NONE);

  // State register; reset forces FETCH immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!dec_legal)                              state_d = S_TRAP;
        else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MADDR;
        else if (opcode == OP_R)                     state_d = S_EXR;
        else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BR;
        else if (opcode == OP_J)                     state_d = S_JMP;
        else                                         state_d = S_EXI;
      end
      S_MADDR:  state_d = (opcode == OP_SW) ? S_MWR : S_MRD;
      S_MRD:    state_d = S_MWB;
      S_EXR:    state_d = ovf_trap ? S_TRAP : S_RWB;
      S_EXI:    state_d = ovf_trap ? S_TRAP : S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore strobe decode, all forced low while reset is held.
  always_comb begin
    alu_op     = 4'd0;
    ins        = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_zero   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'd0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;
    if (!rst) begin
      alu_op   = dec_alu_op;
      ins      = dec_ins;
      ext_zero = dec_ext_zero;
      case (state_q)
        S_FETCH:  begin mem_read = 1'b1; ir_write = 1'b1; pc_write = 1'b1; alu_src_b = 2'd1; end
        S_DECODE: alu_src_b = 2'd3;
        S_MADDR:  begin alu_src_a = 1'b1; alu_src_b = 2'd2; end
        S_MRD:    begin iord = 1'b1; mem_read = 1'b1; end
        S_MWB:    begin reg_write = 1'b1; mem_to_reg = 1'b1; end
        S_MWR:    begin iord = 1'b1; mem_write = 1'b1; end
        S_EXR:    alu_src_a = 1'b1;
        S_RWB:    begin reg_write = 1'b1; reg_dst = 1'b1; end
        S_EXI:    begin alu_src_a = 1'b1; alu_src_b = 2'd2; end
        S_IWB:    reg_write = 1'b1;
        S_BR: begin
          alu_src_a = 1'b1;
          pc_source = 2'd1;
          pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
        end
        S_JMP:    begin pc_write = 1'b1; pc_source = 2'd2; end
        S_TRAP:   trap = 1'b1;
        default:  trap = 1'b0;
      endcase
    end
  end

  // Retirement is the completing edge back into FETCH; TRAP never retires.
  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MWB, S_MWR, S_RWB, S_IWB, S_BR, S_JMP});

  always_comb begin
    instr_cnt_d = retire ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
    trap_cnt_d  = (state_q == S_TRAP) ? trap_cnt_q + CNT_W'(1) : trap_cnt_q;
  end

  // Retired-instruction and trap counters, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt_q <= '0;
      trap_cnt_q  <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      trap_cnt_q  <= trap_cnt_d;
    end
  end

  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;
  assign trap_cnt  = trap_cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: each scenario queues the expected
// per-cycle output vector, then drains the queue against the DUT.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0, funct = '0;
  logic        zero = 1'b0, overflow = 1'b0;
  logic [3:0]  alu_op;
  logic [1:0]  ins;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        ext_zero, pc_write;
  logic [1:0]  pc_source;
  logic        iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, trap;
  logic [3:0]  state;
  logic [31:0] instr_cnt, trap_cnt;

  typedef struct packed {
    logic [3:0]  st;
    logic [3:0]  aop;
    logic [1:0]  ins;
    logic        sa;
    logic [1:0]  sb;
    logic        ez;
    logic        pcw;
    logic [1:0]  pcs;
    logic        iord, mr, mw, irw, rw, rd, m2r, trap;
    logic [31:0] ic, tc;
  } exp_t;

  exp_t sb[$];
  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_ic = 0, exp_tc = 0;

  mc_ctrl_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
    .alu_op(alu_op), .ins(ins), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .pc_write(pc_write), .pc_source(pc_source), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .trap(trap), .state(state),
    .instr_cnt(instr_cnt), .trap_cnt(trap_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1);
  end

  function automatic exp_t obs();
    exp_t o;
    o = '{st:state, aop:alu_op, ins:ins, sa:alu_src_a, sb:alu_src_b, ez:ext_zero,
          pcw:pc_write, pcs:pc_source, iord:iord, mr:mem_read, mw:mem_write, irw:ir_write,
          rw:reg_write, rd:reg_dst, m2r:mem_to_reg, trap:trap, ic:instr_cnt, tc:trap_cnt};
    return o;
  endfunction

  // Reference Moore outputs per state; ALU codes for EX states and the branch
  // decision are filled in by each scenario.
  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e = '0; e.st = st; e.ic = exp_ic; e.tc = exp_tc;
    case (st)
      4'd0:  begin e.mr = 1; e.irw = 1; e.pcw = 1; e.sb = 2'd1; e.aop = 4'd1; end
      4'd1:  begin e.sb = 2'd3; e.aop = 4'd1; end
      4'd2:  begin e.sa = 1; e.sb = 2'd2; e.aop = 4'd1; end
      4'd3:  begin e.iord = 1; e.mr = 1; end
      4'd4:  begin e.rw = 1; e.m2r = 1; end
      4'd5:  begin e.iord = 1; e.mw = 1; end
      4'd6:  e.sa = 1;
      4'd7:  begin e.rw = 1; e.rd = 1; end
      4'd8:  begin e.sa = 1; e.aop = 4'd2; e.pcs = 2'd1; end
      4'd9:  begin e.pcw = 1; e.pcs = 2'd2; end
      4'd10: begin e.sa = 1; e.sb = 2'd2; end
      4'd11: e.rw = 1;
      4'd12: e.trap = 1;
      default: e.st = st;
    endcase
    return e;
  endfunction

  function automatic exp_t mkx(input logic [3:0] st, input logic [3:0] aop, input logic [1:0] i);
    exp_t e;
    e = mk(st); e.aop = aop; e.ins = i;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e, o;
    e = '0;
    repeat (2) begin
      @(negedge clk);
      o = obs(); nvec++;
      if (o !== e) begin nerr++; $display("FAIL reset_state: got %h expected %h", o, e); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add_ovf();
    exp_t e, o;
    opcode = 6'h00; funct = 6'h20; overflow = 1'b1;
    sb.push_back(mk(0)); sb.push_back(mk(1));
    sb.push_back(mkx(6, 4'd1, 2'b01)); sb.push_back(mk(12));
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front(); o = obs(); nvec++;
      if (o !== e) begin nerr++; $display("FAIL add_ovf: got %h expected %h", o, e); end
      @(posedge clk); #1;
    end
    exp_tc++;
    overflow = 1'b0;
  endtask

  task automatic test_addu();
    exp_t e, o;
    opcode = 6'h00; funct = 6'h21; overflow = 1'b1;
    sb.push_back(mk(0)); sb.push_back(mk(1));
    sb.push_back(mkx(6, 4'd1, 2'b00)); sb.push_back(mk(7));
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front(); o = obs(); nvec++;
      if (o !== e) begin nerr++; $display("FAIL addu_ovf: got %h expected %h", o, e); end
      @(posedge clk); #1;
    end
    exp_ic++;
    overflow = 1'b0;
  endtask

  task automatic test_branch();
    exp_t e, o;
    for (int k = 0; k < 2; k++) begin
      opcode = (k == 0) ? 6'h04 : 6'h05; zero = 1'b1;
      sb.push_back(mk(0)); sb.push_back(mk(1));
      e = mk(8); e.pcw = (k == 0); sb.push_back(e);
      while (sb.size() != 0) begin
        @(negedge clk);
        e = sb.pop_front(); o = obs(); nvec++;
        if (o !== e) begin nerr++; $display("FAIL branch_%0d: got %h expected %h", k, o, e); end
        @(posedge clk); #1;
      end
      exp_ic++;
    end
    zero = 1'b0;
  endtask

  task automatic test_lw_sw();
    exp_t e, o;
    opcode = 6'h23;
    sb.push_back(mk(0)); sb.push_back(mk(1)); sb.push_back(mk(2));
    sb.push_back(mk(3)); sb.push_back(mk(4));
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front(); o = obs(); nvec++;
      if (o !== e) begin nerr++; $display("FAIL lw: got %h expected %h", o, e); end
      @(posedge clk); #1;
    end
    exp_ic++;
    opcode = 6'h2B;
    sb.push_back(mk(0)); sb.push_back(mk(1)); sb.push_back(mk(2)); sb.push_back(mk(5));
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front(); o = obs(); nvec++;
      if (o !== e) begin nerr++; $display("FAIL sw: got %h expected %h", o, e); end
      @(posedge clk); #1;
    end
    exp_ic++;
  endtask

  task automatic test_illegal();
    exp_t e, o;
    for (int k = 0; k < 2; k++) begin
      opcode = (k == 0) ? 6'h3F : 6'h00; funct = 6'h00;
      sb.push_back(mk(0)); sb.push_back(mk(1)); sb.push_back(mk(12));
      while (sb.size() != 0) begin
        @(negedge clk);
        e = sb.pop_front(); o = obs(); nvec++;
        if (o !== e) begin nerr++; $display("FAIL illegal_%0d: got %h expected %h", k, o, e); end
        @(posedge clk); #1;
      end
      exp_tc++;
    end
  endtask

  task automatic test_imm_jmp();
    exp_t e, o;
    // andi: zero-extended AND, writes back
    opcode = 6'h0C;
    sb.push_back(mk(0)); sb.push_back(mk(1));
    e = mkx(10, 4'd3, 2'b00); e.ez = 1; sb.push_back(e); sb.push_back(mk(11));
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front(); o = obs(); nvec++;
      if (o !== e) begin nerr++; $display("FAIL andi: got %h expected %h", o, e); end
      @(posedge clk); #1;
    end
    exp_ic++;
    // addi with overflow traps
    opcode = 6'h08; overflow = 1'b1;
    sb.push_back(mk(0)); sb.push_back(mk(1));
    sb.push_back(mkx(10, 4'd1, 2'b01)); sb.push_back(mk(12));
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front(); o = obs(); nvec++;
      if (o !== e) begin nerr++; $display("FAIL addi_ovf: got %h expected %h", o, e); end
      @(posedge clk); #1;
    end
    exp_tc++;
    // slti ignores overflow
    opcode = 6'h0A;
    sb.push_back(mk(0)); sb.push_back(mk(1));
    sb.push_back(mkx(10, 4'd8, 2'b00)); sb.push_back(mk(11));
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front(); o = obs(); nvec++;
      if (o !== e) begin nerr++; $display("FAIL slti: got %h expected %h", o, e); end
      @(posedge clk); #1;
    end
    exp_ic++;
    overflow = 1'b0;
    // R-type sltu then jump
    opcode = 6'h00; funct = 6'h2B;
    sb.push_back(mk(0)); sb.push_back(mk(1));
    sb.push_back(mkx(6, 4'd7, 2'b00)); sb.push_back(mk(7));
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front(); o = obs(); nvec++;
      if (o !== e) begin nerr++; $display("FAIL sltu: got %h expected %h", o, e); end
      @(posedge clk); #1;
    end
    exp_ic++;
    opcode = 6'h02;
    sb.push_back(mk(0)); sb.push_back(mk(1)); sb.push_back(mk(9));
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front(); o = obs(); nvec++;
      if (o !== e) begin nerr++; $display("FAIL jmp: got %h expected %h", o, e); end
      @(posedge clk); #1;
    end
    exp_ic++;
  endtask

  task automatic test_rst_mid();
    exp_t e, o;
    opcode = 6'h23;
    sb.push_back(mk(0)); sb.push_back(mk(1)); sb.push_back(mk(2));
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front(); o = obs(); nvec++;
      if (o !== e) begin nerr++; $display("FAIL rst_mid_pre: got %h expected %h", o, e); end
      @(posedge clk); #1;
    end
    // now in MRD; assert reset asynchronously mid-cycle
    #2;
    e = mk(3); o = obs(); nvec++;
    if (o !== e) begin nerr++; $display("FAIL rst_mid_mrd: got %h expected %h", o, e); end
    rst = 1'b1;
    exp_ic = 0; exp_tc = 0;
    #1;
    e = '0; o = obs(); nvec++;
    if (o !== e) begin nerr++; $display("FAIL rst_mid_async: got %h expected %h", o, e); end
    @(negedge clk);
    o = obs(); nvec++;
    if (o !== e) begin nerr++; $display("FAIL rst_mid_hold: got %h expected %h", o, e); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    e = mk(0); o = obs(); nvec++;
    if (o !== e) begin nerr++; $display("FAIL rst_mid_after: got %h expected %h", o, e); end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_addu();
    test_branch();
    test_lw_sw();
    test_illegal();
    test_imm_jmp();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
